// File: rtl/regfile_wb_queue.sv
// Purpose: buffers ALU/load writeback results and drains them in order to the register-file write port; optional operand bypass (macro WBQ_BYPASS_EN).
// Latency: an entry accepted at edge N is presented on rf_rd_* in the next cycle; earliest commit at edge N+1.
// Backpressure: combinational readies from free slots (pop-aware); load wins the last slot; rf_stall holds the head entry.
module regfile_wb_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     ld_ready,
  input  logic                     rf_stall,
  output logic                     rf_rd_write,
  output logic [AW-1:0]            rf_rd_addr,
  output logic [XLEN-1:0]          rf_rd_data,
  input  logic [AW-1:0]            rs1_addr,
  input  logic [AW-1:0]            rs2_addr,
  output logic                     rs1_hit,
  output logic                     rs2_hit,
  output logic [XLEN-1:0]          rs1_fwd,
  output logic [XLEN-1:0]          rs2_fwd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]   rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   alu_slot;
  logic [CW-1:0]   free;
  logic            not_empty;
  logic            pop;
  logic            ld_push;
  logic            alu_push;

  assign not_empty = (count != '0);
  assign pop       = not_empty && !rf_stall;

  // Head entry drives the write port; zeros when nothing is queued.
  assign rf_rd_write = pop;
  assign rf_rd_addr  = not_empty ? rd_mem[head]   : '0;
  assign rf_rd_data  = not_empty ? data_mem[head] : '0;

  // A slot freed by this cycle's pop is reusable in the same cycle.
  assign free = CW'(DEPTH) - count + CW'(pop);

  // Readies are forced low while reset is held, even though free would read DEPTH.
  assign ld_ready  = rst_n && (free >= CW'(1));
  assign alu_ready = rst_n && ((free >= CW'(2)) || ((free >= CW'(1)) && !ld_valid));

  // rd = 0 completes the handshake but never occupies a slot.
  assign ld_push  = ld_valid  && ld_ready  && (ld_rd  != '0);
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);

  // When both push, the load takes the older slot and the ALU the one after it.
  assign alu_slot = tail + PW'(ld_push);

  // Entry storage: validity is tracked by head/count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (ld_push) begin
      rd_mem[tail]   <= ld_rd;
      data_mem[tail] <= ld_data;
    end
    if (alu_push) begin
      rd_mem[alu_slot]   <= alu_rd;
      data_mem[alu_slot] <= alu_data;
    end
  end

  // Pointer and occupancy update; reset discards all queued entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(ld_push) + PW'(alu_push);
      count <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
    end
  end

`ifdef WBQ_BYPASS_EN
  // Scan stored entries oldest to youngest so the youngest match wins.
  always_comb begin
    rs1_hit = 1'b0;
    rs1_fwd = '0;
    rs2_hit = 1'b0;
    rs2_fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if ((rs1_addr != '0) && (rd_mem[head + PW'(i)] == rs1_addr)) begin
          rs1_hit = 1'b1;
          rs1_fwd = data_mem[head + PW'(i)];
        end
        if ((rs2_addr != '0) && (rd_mem[head + PW'(i)] == rs2_addr)) begin
          rs2_hit = 1'b1;
          rs2_fwd = data_mem[head + PW'(i)];
        end
      end
    end
  end
`else
  // Bypass not built: operand ports stay but never report a hit.
  logic unused_rs_addr;
  assign unused_rs_addr = ^{rs1_addr, rs2_addr};
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
  assign rs1_fwd = '0;
  assign rs2_fwd = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus randomized traffic against a queue model.
// Inputs change 1ns after the rising edge; outputs are sampled a few ns later, before the next edge.
// Expected bypass values follow WBQ_BYPASS_EN in the same way as the design build.
module tb_regfile_wb_queue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [AW-1:0]   alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            alu_ready;
  logic            ld_valid = 1'b0;
  logic [AW-1:0]   ld_rd = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic            ld_ready;
  logic            rf_stall = 1'b0;
  logic            rf_rd_write;
  logic [AW-1:0]   rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;
  logic [AW-1:0]   rs1_addr = '0;
  logic [AW-1:0]   rs2_addr = '0;
  logic            rs1_hit;
  logic            rs2_hit;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [CW-1:0]   count;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t mq[$];

  regfile_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_stall(rf_stall), .rf_rd_write(rf_rd_write), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending writes.
  function automatic bit m_write();
    return (mq.size() != 0) && !rf_stall;
  endfunction

  function automatic int m_free();
    return DEPTH - mq.size() + (m_write() ? 1 : 0);
  endfunction

  function automatic bit m_ld_rdy();
    return m_free() >= 1;
  endfunction

  function automatic bit m_alu_rdy();
    return (m_free() >= 2) || (m_free() >= 1 && !ld_valid);
  endfunction

  function automatic logic [AW-1:0] m_addr();
    return (mq.size() != 0) ? mq[0].rd : '0;
  endfunction

  function automatic logic [XLEN-1:0] m_data();
    return (mq.size() != 0) ? mq[0].data : '0;
  endfunction

  // {hit, value} of the youngest queued write to register a.
  function automatic logic [XLEN:0] m_fwd(input logic [AW-1:0] a);
`ifdef WBQ_BYPASS_EN
    for (int i = mq.size() - 1; i >= 0; i--)
      if (a != '0 && mq[i].rd == a) return {1'b1, mq[i].data};
`endif
    return '0;
  endfunction

  task automatic tick();
    bit w, la, aa;
    ent_t e;
    w  = m_write();
    la = ld_valid && m_ld_rdy();
    aa = alu_valid && m_alu_rdy();
    @(posedge clk);
    if (w) e = mq.pop_front();
    if (la && ld_rd != '0) begin e.rd = ld_rd; e.data = ld_data; mq.push_back(e); end
    if (aa && alu_rd != '0) begin e.rd = alu_rd; e.data = alu_data; mq.push_back(e); end
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; alu_rd = '0; ld_rd = '0;
    alu_data = '0; ld_data = '0; rf_stall = 1'b0; rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mq.delete();
    idle_inputs();
    alu_valid = 1'b1; ld_valid = 1'b1; alu_rd = 5'd1; ld_rd = 5'd2;
    #2;
    n_chk++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready got %0b want 0", ld_ready); end
    n_chk++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready got %0b want 0", alu_ready); end
    n_chk++; if (rf_rd_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got %0b want 0", rf_rd_write); end
    n_chk++; if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_chk++; if ({rf_rd_addr, rf_rd_data} !== '0) begin n_fail++; $display("FAIL reset_rf_bus got %0h/%0h want 0", rf_rd_addr, rf_rd_data); end
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h11;
    #2;
    n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready got %0b want 1", alu_ready); end
    n_chk++; if (rf_rd_write !== 1'b0) begin n_fail++; $display("FAIL single_early_write got %0b want 0", rf_rd_write); end
    tick();
    alu_valid = 1'b0;
    #2;
    n_chk++; if (rf_rd_write !== 1'b1) begin n_fail++; $display("FAIL single_write got %0b want 1", rf_rd_write); end
    n_chk++; if (rf_rd_addr !== 5'd3) begin n_fail++; $display("FAIL single_addr got %0d want 3", rf_rd_addr); end
    n_chk++; if (rf_rd_data !== 64'h11) begin n_fail++; $display("FAIL single_data got %0h want 11", rf_rd_data); end
    tick();
    n_chk++; if (count !== CW'(0)) begin n_fail++; $display("FAIL single_count_after got %0d want 0", count); end
  endtask

  task automatic test_load_priority();
    logic [AW-1:0] exp_rd [4];
    exp_rd[0] = 5'd1; exp_rd[1] = 5'd2; exp_rd[2] = 5'd3; exp_rd[3] = 5'd4;
    rf_stall = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      alu_valid = 1'b1; alu_rd = exp_rd[i]; alu_data = 64'h100 + 64'(i);
      tick();
    end
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h300;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 64'h200;
    #2;
    n_chk++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ld_ready got %0b want 1", ld_ready); end
    n_chk++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL prio_alu_ready got %0b want 0", alu_ready); end
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    n_chk++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL prio_count got %0d want %0d", count, DEPTH); end
    rf_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      n_chk++; if (rf_rd_write !== 1'b1 || rf_rd_addr !== exp_rd[i]) begin
        n_fail++; $display("FAIL prio_drain%0d got wr=%0b rd=%0d want wr=1 rd=%0d", i, rf_rd_write, rf_rd_addr, exp_rd[i]);
      end
      tick();
    end
    n_chk++; if (count !== CW'(0)) begin n_fail++; $display("FAIL prio_empty got %0d want 0", count); end
  endtask

  task automatic test_same_rd();
    rf_stall = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 64'hA;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hB;
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    #2;
    n_chk++; if (rs1_hit !== 1'b0) begin n_fail++; $display("FAIL same_rd_no_inflight_fwd got %0b want 0", rs1_hit); end
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    #2;
`ifdef WBQ_BYPASS_EN
    n_chk++; if (rs1_hit !== 1'b1 || rs1_fwd !== 64'hB) begin n_fail++; $display("FAIL same_rd_fwd got hit=%0b %0h want hit=1 b", rs1_hit, rs1_fwd); end
`else
    n_chk++; if (rs1_hit !== 1'b0 || rs1_fwd !== '0) begin n_fail++; $display("FAIL same_rd_fwd got hit=%0b %0h want hit=0 0", rs1_hit, rs1_fwd); end
`endif
    n_chk++; if (rs2_hit !== 1'b0) begin n_fail++; $display("FAIL same_rd_rs2_miss got %0b want 0", rs2_hit); end
    rf_stall = 1'b0;
    #2;
    n_chk++; if (rf_rd_write !== 1'b1 || rf_rd_data !== 64'hA) begin n_fail++; $display("FAIL same_rd_first got wr=%0b %0h want wr=1 a", rf_rd_write, rf_rd_data); end
    tick();
    #2;
`ifdef WBQ_BYPASS_EN
    n_chk++; if (rs1_hit !== 1'b1) begin n_fail++; $display("FAIL same_rd_head_hit got %0b want 1", rs1_hit); end
`endif
    n_chk++; if (rf_rd_write !== 1'b1 || rf_rd_data !== 64'hB) begin n_fail++; $display("FAIL same_rd_second got wr=%0b %0h want wr=1 b", rf_rd_write, rf_rd_data); end
    tick();
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
    #2;
    n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %0b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #2;
    n_chk++; if (count !== CW'(0)) begin n_fail++; $display("FAIL rd0_count got %0d want 0", count); end
    n_chk++; if (rf_rd_write !== 1'b0) begin n_fail++; $display("FAIL rd0_write got %0b want 0", rf_rd_write); end
  endtask

  task automatic test_full_stream();
    ent_t exp_q[$];
    ent_t e;
    rf_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      e.rd = AW'(8 + i); e.data = {$urandom, $urandom};
      alu_valid = 1'b1; alu_rd = e.rd; alu_data = e.data;
      exp_q.push_back(e);
      tick();
    end
    alu_rd = 5'd20;
    #2;
    n_chk++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_stalled_ready got alu=%0b ld=%0b want 0/0", alu_ready, ld_ready); end
    rf_stall = 1'b0;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      e.rd = AW'(1 + k); e.data = {$urandom, $urandom};
      alu_valid = 1'b1; alu_rd = e.rd; alu_data = e.data;
      #2;
      n_chk++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d got %0b want 1", k, alu_ready); end
      n_chk++; if (rf_rd_write !== 1'b1 || rf_rd_addr !== exp_q[0].rd || rf_rd_data !== exp_q[0].data) begin
        n_fail++; $display("FAIL stream_out%0d got wr=%0b %0d:%0h want 1 %0d:%0h", k, rf_rd_write, rf_rd_addr, rf_rd_data, exp_q[0].rd, exp_q[0].data);
      end
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(e);
      n_chk++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL stream_count%0d got %0d want %0d", k, count, DEPTH); end
    end
    alu_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #2;
      n_chk++; if (rf_rd_write !== 1'b1 || rf_rd_addr !== exp_q[0].rd || rf_rd_data !== exp_q[0].data) begin
        n_fail++; $display("FAIL stream_tail%0d got wr=%0b %0d:%0h want 1 %0d:%0h", k, rf_rd_write, rf_rd_addr, rf_rd_data, exp_q[0].rd, exp_q[0].data);
      end
      tick();
      void'(exp_q.pop_front());
    end
    n_chk++; if (count !== CW'(0)) begin n_fail++; $display("FAIL stream_empty got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = AW'(12 + i); alu_data = 64'h500 + 64'(i);
      tick();
    end
    alu_valid = 1'b0;
    rf_stall = 1'b0; rs1_addr = 5'd13;
    #2;
    n_chk++; if (rf_rd_write !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_write got %0b want 1", rf_rd_write); end
    rst_n = 1'b0;
    mq.delete();
    #1;
    n_chk++; if (rf_rd_write !== 1'b0 || rf_rd_addr !== '0 || rf_rd_data !== '0) begin
      n_fail++; $display("FAIL rstmid_rf_bus got wr=%0b %0d:%0h want 0", rf_rd_write, rf_rd_addr, rf_rd_data);
    end
    n_chk++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got %0b/%0b want 0/0", alu_ready, ld_ready); end
    n_chk++; if (rs1_hit !== 1'b0 || rs1_fwd !== '0) begin n_fail++; $display("FAIL rstmid_bypass got %0b %0h want 0", rs1_hit, rs1_fwd); end
    @(negedge clk) rst_n = 1'b1;
    rs1_addr = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (count !== CW'(0) || rf_rd_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_after%0d got cnt=%0d wr=%0b want 0/0", i, count, rf_rd_write); end
    end
  endtask

  task automatic test_random();
    logic [XLEN:0] f1, f2;
    for (int c = 0; c < 400; c++) begin
      ld_valid  = ($urandom_range(0, 1) == 1);
      alu_valid = ($urandom_range(0, 1) == 1);
      ld_rd  = AW'($urandom_range(0, 7)); ld_data  = {$urandom, $urandom};
      alu_rd = AW'($urandom_range(0, 7)); alu_data = {$urandom, $urandom};
      rf_stall = ($urandom_range(0, 9) < 4);
      rs1_addr = AW'($urandom_range(0, 7)); rs2_addr = AW'($urandom_range(0, 7));
      #2;
      f1 = m_fwd(rs1_addr); f2 = m_fwd(rs2_addr);
      n_chk++; if (count !== CW'(mq.size()) || count > CW'(DEPTH)) begin n_fail++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count, mq.size()); end
      n_chk++; if (ld_ready !== m_ld_rdy()) begin n_fail++; $display("FAIL rnd_ld_ready c%0d got %0b want %0b", c, ld_ready, m_ld_rdy()); end
      n_chk++; if (alu_ready !== m_alu_rdy()) begin n_fail++; $display("FAIL rnd_alu_ready c%0d got %0b want %0b", c, alu_ready, m_alu_rdy()); end
      n_chk++; if (rf_rd_write !== m_write()) begin n_fail++; $display("FAIL rnd_write c%0d got %0b want %0b", c, rf_rd_write, m_write()); end
      n_chk++; if (rf_rd_addr !== m_addr() || rf_rd_data !== m_data()) begin
        n_fail++; $display("FAIL rnd_head c%0d got %0d:%0h want %0d:%0h", c, rf_rd_addr, rf_rd_data, m_addr(), m_data());
      end
      n_chk++; if ({rs1_hit, rs1_fwd} !== f1) begin n_fail++; $display("FAIL rnd_rs1 c%0d got %0b:%0h want %0h", c, rs1_hit, rs1_fwd, f1); end
      n_chk++; if ({rs2_hit, rs2_fwd} !== f2) begin n_fail++; $display("FAIL rnd_rs2 c%0d got %0b:%0h want %0h", c, rs2_hit, rs2_fwd, f2); end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) tick();
    n_chk++; if (count !== CW'(0)) begin n_fail++; $display("FAIL rnd_drained got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_load_priority();
    test_same_rd();
    test_rd_zero();
    test_full_stream();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side companion of the 64-bit integer register file: buffers writeback results from the ALU and load unit and drains them into the register-file write port, one entry per cycle, in program order.
- Also answers operand reads from the queue, so decode sees values not yet committed to the register file.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- XLEN, 64, data width of register values.
- DEPTH, 4, queue entries; power of two, ≥2.
- AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- ld_valid  in  1  load writeback request.
- ld_rd  in  AW  load destination register.
- ld_data  in  XLEN  load result.
- ld_ready  out  1  load request accepted this cycle.
- rf_stall  in  1  register-file write port unavailable this cycle.
- rf_rd_write  out  1  write enable to register file.
- rf_rd_addr  out  AW  write address.
- rf_rd_data  out  XLEN  write data.
- rs1_addr, rs2_addr  in  AW  operand addresses from decode.
- rs1_hit, rs2_hit  out  1  a pending write to that register is queued.
- rs1_fwd, rs2_fwd  out  XLEN  newest queued value for that register.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Circular FIFO of {rd, data}; head/tail pointers wrap modulo DEPTH; count is an explicit register, not derived from the pointers.
- Reset (rst_n low, async): pointers and count go to 0. While rst_n is low, alu_ready=ld_ready=0 and rf_rd_write=0, rf_rd_addr=0, rf_rd_data=0, all hit=0, all fwd=0. Reset mid-drain discards every queued entry, with no partial write.
- Drain:
  - rf_rd_write = (count≠0) && !rf_stall.
  - rf_rd_addr and rf_rd_data present the head entry, and are 0 when empty.
  - pop = rf_rd_write; head advances on that edge.
- Free slots this cycle: free = DEPTH − count + pop.
- Acceptance (combinational readies):
  - ld_ready = (free ≥ 1).
  - alu_ready = (free ≥ 2) || (free ≥ 1 && !ld_valid).
  - Load has priority when only one slot is free.
  - Both accepted in the same cycle: load entry enqueued first (older), ALU entry second.
- rd = 0 requests: handshake completes normally, but no entry is stored and no slot is consumed. Readiness is still computed as above.
- Simultaneous push and pop when full: legal. pop frees a slot in the same cycle (free includes pop).
- Latency: an entry accepted at edge N is first driven on rf_rd_* in the cycle after edge N. The earliest register-file write is at edge N+1, if it is at the head and rf_stall=0.
- Ordering: entries drain strictly FIFO. Writes to the same rd commit in enqueue order.
- count next = count + pushes − pop, where pushes ∈ {0,1,2}. Overflow is impossible by construction; the assertion is part of the bench.
- Bypass (combinational over stored entries only):
  - rsX_hit = (rsX_addr≠0) && some valid entry has rd == rsX_addr.
  - rsX_fwd = data of the youngest matching entry, else 0.
  - Requests arriving in the current cycle are not forwarded.
  - The head entry being written this cycle still counts as a hit.

Optional Feature:
- Macro WBQ_BYPASS_EN.
- Defined: rs1/rs2 hit and fwd behave as above.
- Undefined: the match logic is not built; rs1_hit, rs2_hit, rs1_fwd, rs2_fwd are tied to 0. Ports remain present. All other behaviour is identical.

Test Plan:
- Reset, then a single ALU push rd=3 data=0x11 → cycle after acceptance: rf_rd_write=1, addr=3, data=0x11; count returns to 0.
- ld_valid and alu_valid together with count=DEPTH−1, rf_stall=1 → ld_ready=1, alu_ready=0; count=DEPTH. Release stall → entries drain in order.
- Both push rd=5: load data=0xA, ALU data=0xB, rf_stall=1; rs1_addr=5 → rs1_hit=1, rs1_fwd=0xB. Drain writes 0xA, then 0xB.
- ALU push rd=0 data=0xFF → alu_ready=1, count unchanged, no rf_rd_write.
- Fill to DEPTH with rf_stall=1. Drop stall while pushing 1 entry every cycle → accepted each cycle; count holds at DEPTH; pointers wrap with no lost or duplicated entries.
- Queue holding 3 entries; assert rst_n=0 mid-cycle → outputs 0 immediately. After release: count=0 and no writes issued.
